// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the I/D cache memory arbiter.
package mem_arbiter_pkg;

  localparam int LINE_WORDS_DEF = 8;
  localparam int IDX_W = $clog2(LINE_WORDS_DEF);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BURST_I = 2'd1,
    BURST_D = 2'd2,
    DONE    = 2'd3
  } state_t;

endpackage

// File: rtl/mem_arbiter_burst_counter.sv
// Word index within a cache-line burst; wraps to zero after the last word.
module burst_counter
  import mem_arbiter_pkg::*;
#(
  parameter int LINE_WORDS = LINE_WORDS_DEF
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          en,
  input  logic                          clr,
  output logic [$clog2(LINE_WORDS)-1:0] value,
  output logic                          last
);

  localparam int IW = $clog2(LINE_WORDS);

  // LINE_WORDS is a power of two, so the natural overflow is the wrap.
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      value <= '0;
    end else if (en) begin
      value <= value + IW'(1);
    end
  end

  assign last = (value == IW'(LINE_WORDS - 1));

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter granting whole cache-line bursts to the ICache or DCache.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int LINE_WORDS = LINE_WORDS_DEF,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          ReqI,
  input  logic [ADDR_W-1:0]             AddrI,
  input  logic                          ReqD,
  input  logic                          WeD,
  input  logic [ADDR_W-1:0]             AddrD,
  input  logic [DATA_W-1:0]             WDataD,
  output logic                          MemReq,
  output logic                          MemWe,
  output logic [ADDR_W-1:0]             MemAddr,
  output logic [DATA_W-1:0]             MemWData,
  input  logic                          MemAck,
  input  logic [DATA_W-1:0]             MemRData,
  output logic [DATA_W-1:0]             RData,
  output logic                          RValidI,
  output logic                          RValidD,
  output logic [$clog2(LINE_WORDS)-1:0] WordIdx,
  output logic                          DoneI,
  output logic                          DoneD
);

  localparam int IW    = $clog2(LINE_WORDS);
  localparam int OFS_W = IW + 2;
  localparam logic [ADDR_W-1:0] LINE_MASK = {{(ADDR_W - OFS_W){1'b1}}, {OFS_W{1'b0}}};

  state_t            state;
  state_t            state_next;
  logic              last_d;
  logic              base_we;
  logic [ADDR_W-1:0] base;
  logic              grant_i;
  logic              grant_d;
  logic              in_burst;
  logic              idx_last;

  // A tie goes to whoever was not served last; a lone request always wins.
  assign grant_d  = ReqD && (!ReqI || !last_d);
  assign grant_i  = ReqI && !grant_d;
  assign in_burst = (state == BURST_I) || (state == BURST_D);

  burst_counter #(
    .LINE_WORDS(LINE_WORDS)
  ) u_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (in_burst && MemAck),
    .clr  (!in_burst),
    .value(WordIdx),
    .last (idx_last)
  );

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (grant_d) begin
          state_next = BURST_D;
        end else if (grant_i) begin
          state_next = BURST_I;
        end
      end
      BURST_I, BURST_D: begin
        if (MemAck && idx_last) begin
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // last_d doubles as the owner of the current burst, since it is set at grant.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      last_d  <= 1'b0;
      base    <= '0;
      base_we <= 1'b0;
    end else begin
      state <= state_next;
      if (state == IDLE && (grant_i || grant_d)) begin
        last_d  <= grant_d;
        base    <= (grant_d ? AddrD : AddrI) & LINE_MASK;
        base_we <= grant_d && WeD;
      end
    end
  end

  assign MemReq   = in_burst;
  assign MemWe    = (state == BURST_D) && base_we;
  assign MemAddr  = in_burst ? (base + ADDR_W'({WordIdx, 2'b00})) : '0;
  assign MemWData = in_burst ? WDataD : '0;
  assign RData    = MemRData;
  assign RValidI  = (state == BURST_I) && MemAck;
  assign RValidD  = (state == BURST_D) && MemAck && !base_we;
  assign DoneI    = (state == DONE) && !last_d;
  assign DoneD    = (state == DONE) && last_d;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized scoreboard bench for mem_arbiter against a transaction-level model.
`timescale 1ns/1ps
module tb_mem_arbiter;

  localparam int LW = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ReqI, ReqD, WeD;
  logic [31:0] AddrI, AddrD, WDataD;
  logic        MemReq, MemWe, MemAck;
  logic [31:0] MemAddr, MemWData, MemRData, RData;
  logic        RValidI, RValidD, DoneI, DoneD;
  logic [2:0]  WordIdx;

  typedef struct {
    logic        is_d;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        last;
    logic        gap2;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] d_line [LW];
  int          n_chk = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          ack_mode = 3;
  int          ack_div = 0;
  logic        model_last_d = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign WDataD = d_line[WordIdx];

  mem_arbiter #(.LINE_WORDS(LW), .ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .ReqI(ReqI), .AddrI(AddrI), .ReqD(ReqD), .WeD(WeD),
    .AddrD(AddrD), .WDataD(WDataD), .MemReq(MemReq), .MemWe(MemWe), .MemAddr(MemAddr),
    .MemWData(MemWData), .MemAck(MemAck), .MemRData(MemRData), .RData(RData),
    .RValidI(RValidI), .RValidD(RValidD), .WordIdx(WordIdx), .DoneI(DoneI), .DoneD(DoneD)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Memory responder: acks regardless of MemReq, so stray acks in IDLE occur too.
  always @(posedge clk) begin
    #1;
    case (ack_mode)
      0: MemAck = ($urandom_range(0, 1) == 1);
      1: MemAck = 1'b1;
      2: begin
        ack_div = (ack_div == 2) ? 0 : ack_div + 1;
        MemAck  = (ack_div == 2);
      end
      default: MemAck = 1'b0;
    endcase
    MemRData = (ack_mode == 3) ? 32'h0 : $urandom;
  end

  // Monitor: compares every burst cycle against the head of the expectation queue.
  logic last_prev = 1'b0, last_owner_d = 1'b0, req_prev = 1'b0;
  int   done_cyc = -100;
  always @(negedge clk) begin
    exp_t e;
    logic last_now;
    last_now = 1'b0;
    if (!rst_n) begin
      last_prev = 1'b0;
      req_prev  = 1'b0;
    end else begin
      if (last_prev || DoneI || DoneD)
        chk("done_pulse", {DoneI, DoneD}, last_prev ? (last_owner_d ? 2'b01 : 2'b10) : 2'b00);
      if (DoneI || DoneD) done_cyc = cyc;
      if (RValidI && RValidD) chk("rvalid_both", 1, 0);
      if (MemReq) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_memreq", MemAddr, 0);
        end else begin
          e = exp_q[0];
          if (!req_prev && e.gap2) chk("burst_gap", cyc - done_cyc, 2);
          chk("mem_addr", MemAddr, e.addr);
          chk("mem_we", MemWe, e.we);
          if (e.we) chk("mem_wdata", MemWData, e.wdata);
          if (MemAck) begin
            chk("rvalid", {RValidI, RValidD}, {!e.is_d && !e.we, e.is_d && !e.we});
            if (!e.we) chk("rdata", RData, MemRData);
            void'(exp_q.pop_front());
            if (e.last) begin
              last_now     = 1'b1;
              last_owner_d = e.is_d;
            end
          end
        end
      end else if (MemAck) begin
        chk("stray_ack_rvalid", {RValidI, RValidD}, 2'b00);
      end
      last_prev = last_now;
      req_prev  = MemReq;
    end
  end

  task automatic push_burst(input logic is_d, input logic we, input logic [31:0] a, input logic gap2);
    exp_t e;
    for (int k = 0; k < LW; k++) begin
      e.is_d  = is_d;
      e.we    = is_d && we;
      e.addr  = (a & ~32'h1F) + 32'(4 * k);
      e.wdata = d_line[k];
      e.last  = (k == LW - 1);
      e.gap2  = gap2 && (k == 0);
      exp_q.push_back(e);
    end
  endtask

  task automatic run_scn(input logic di, input logic dd, input logic we,
                         input logic [31:0] ai, input logic [31:0] ad,
                         input int dly_i, input int dly_d);
    logic first_d;
    for (int k = 0; k < LW; k++) d_line[k] = $urandom;
    if (di && dd) first_d = (dly_i == dly_d) ? !model_last_d : (dly_d < dly_i);
    else          first_d = dd;
    push_burst(first_d, we, first_d ? ad : ai, 1'b0);
    if (di && dd) push_burst(!first_d, we, first_d ? ai : ad, 1'b1);
    model_last_d = (di && dd) ? !first_d : dd;
    $display("scenario: ReqI=%0d ReqD=%0d WeD=%0d AddrI=%h AddrD=%h dly_i=%0d dly_d=%0d ack_mode=%0d",
             di, dd, we, ai, ad, dly_i, dly_d, ack_mode);
    fork
      if (di) begin
        logic got;
        got = 1'b0;
        repeat (dly_i + 1) @(negedge clk);
        AddrI = ai; ReqI = 1'b1;
        for (int t = 0; t < 500 && !got; t++) begin
          @(negedge clk);
          if (DoneI) got = 1'b1;
        end
        ReqI = 1'b0;
        chk("doneI_seen", got, 1);
      end
      if (dd) begin
        logic got;
        got = 1'b0;
        repeat (dly_d + 1) @(negedge clk);
        AddrD = ad; WeD = we; ReqD = 1'b1;
        for (int t = 0; t < 500 && !got; t++) begin
          @(negedge clk);
          if (DoneD) got = 1'b1;
        end
        ReqD = 1'b0; WeD = 1'b0;
        chk("doneD_seen", got, 1);
      end
    join
    repeat (2) @(negedge clk);
  endtask

  task automatic reset_mid_burst();
    int   cnt;
    exp_t e;
    for (int k = 0; k < 4; k++) begin
      e.is_d = 1'b0; e.we = 1'b0; e.addr = 32'h0000_2000 + 32'(4 * k);
      e.wdata = 32'h0; e.last = 1'b0; e.gap2 = 1'b0;
      exp_q.push_back(e);
    end
    ack_mode = 1;
    cnt = 0;
    @(negedge clk);
    AddrI = 32'h0000_2008; ReqI = 1'b1;
    for (int t = 0; t < 100 && cnt < 3; t++) begin
      @(negedge clk);
      if (MemReq && MemAck) cnt++;
    end
    chk("rst_three_acks", cnt, 3);
    ack_mode = 3;
    @(negedge clk);
    rst_n = 1'b0; ReqI = 1'b0;
    @(negedge clk);
    chk("rst_memreq", MemReq, 0);
    chk("rst_wordidx", WordIdx, 0);
    chk("rst_doneI", DoneI, 0);
    $display("reset mid-burst: MemReq=%0d WordIdx=%0d DoneI=%0d", MemReq, WordIdx, DoneI);
    rst_n = 1'b1;
    exp_q.delete();
    model_last_d = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_no_late_done", {DoneI, DoneD}, 2'b00);
    ack_mode = 1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; ReqI = 1'b0; ReqD = 1'b0; WeD = 1'b0;
    AddrI = '0; AddrD = '0; MemAck = 1'b0; MemRData = '0;
    for (int k = 0; k < LW; k++) d_line[k] = $urandom;
    repeat (3) @(negedge clk);
    chk("reset_outputs", |{MemReq, MemWe, MemAddr, MemWData, RData, RValidI, RValidD,
                            WordIdx, DoneI, DoneD}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_outputs", |{MemReq, MemWe, MemAddr, MemWData, RData, RValidI, RValidD,
                                 WordIdx, DoneI, DoneD}, 0);

    ack_mode = 1;
    run_scn(1, 0, 0, 32'h0000_0104, 32'h0, 0, 0);          // lone I refill, ack every cycle
    run_scn(1, 1, 0, 32'h0000_1040, 32'h0000_2080, 0, 0);  // first tie after reset: D first
    run_scn(0, 1, 0, 32'h0, 32'h0000_3000, 0, 0);
    run_scn(1, 1, 0, 32'h0000_4000, 32'h0000_5000, 1, 1);  // tie after D served: I wins
    ack_mode = 2;
    run_scn(0, 1, 1, 32'h0, 32'h0000_6014, 0, 0);          // write-back, ack every 3rd cycle
    ack_mode = 0;
    run_scn(1, 1, 1, 32'h0000_7000, 32'h0000_8000, 3, 0);  // I arrives mid D burst
    reset_mid_burst();
    run_scn(1, 0, 0, 32'h0000_2008, 32'h0, 0, 0);          // restart from word 0

    for (int n = 0; n < 24; n++) begin
      logic di, dd;
      di = 1'($urandom_range(0, 1));
      dd = di ? 1'($urandom_range(0, 1)) : 1'b1;
      ack_mode = $urandom_range(0, 2);
      run_scn(di, dd, 1'($urandom_range(0, 1)), $urandom, $urandom,
              $urandom_range(0, 2), $urandom_range(0, 2));
    end

    repeat (5) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter LINE_WORDS, default 8, words per cache-line burst (power of 2, at least 2).
REQ-002 SHALL have parameter ADDR_W, default 32, byte-address width.
REQ-003 SHALL have parameter DATA_W, default 32, word width.
REQ-004 SHALL have one clock; reset is synchronous and active-low.
REQ-005 clk  in  1  sole clock; all state updates on rising edge.
REQ-006 rst_n  in  1  synchronous active-low reset.
REQ-007 ReqI  in  1  ICache line-refill request, held until DoneI.
REQ-008 AddrI  in  ADDR_W  ICache line base address.
REQ-009 ReqD  in  1  DCache line request, held until DoneD.
REQ-010 WeD  in  1  DCache request type: 1 = write-back, 0 = refill.
REQ-011 AddrD  in  ADDR_W  DCache line base address.
REQ-012 WDataD  in  DATA_W  write-back word selected by WordIdx.
REQ-013 MemReq  out  1  memory word request.
REQ-014 MemWe  out  1  memory write enable.
REQ-015 MemAddr  out  ADDR_W  memory word address.
REQ-016 MemWData  out  DATA_W  memory write data.
REQ-017 MemAck  in  1  one-cycle word-complete strobe; MemRData is valid in the same cycle.
REQ-018 MemRData  in  DATA_W  memory read data.
REQ-019 RData  out  DATA_W  refill word, equal to MemRData.
REQ-020 RValidI, RValidD  out  1 each  refill word valid for the owning cache.
REQ-021 WordIdx  out  log2(LINE_WORDS)  current word index within the burst.
REQ-022 DoneI, DoneD  out  1 each  one-cycle burst-complete pulses.

Function
REQ-023 The FSM SHALL have four states: IDLE, BURST_I, BURST_D, DONE.
REQ-024 IDLE SHALL sample ReqI/ReqD and move next cycle to BURST_I or BURST_D; with neither asserted it SHALL stay in IDLE.
REQ-025 Simultaneous ReqI and ReqD in IDLE SHALL grant the requester not served last (round-robin); the last-served flag SHALL reset to I, so D wins the first tie.
REQ-026 A lone request SHALL be granted regardless of the last-served flag.
REQ-027 Bursts SHALL be non-preemptive: a request arriving mid-burst waits; a request dropped mid-burst does not abort it.
REQ-028 In a BURST state the outputs SHALL be: MemReq=1; MemAddr=base+4*WordIdx, base latched at grant; MemWe = WeD latched for D, 0 for I; MemWData=WDataD.
REQ-029 On each MemAck, WordIdx SHALL increment; MemAck on word LINE_WORDS-1 SHALL wrap WordIdx to 0 and move to DONE.
REQ-030 RValidI/RValidD SHALL equal MemAck qualified by owner and a read burst; they SHALL never both be 1.
REQ-031 DONE SHALL last exactly one cycle with MemReq=0 and a pulse on DoneI or DoneD for the owner, then return to IDLE.
REQ-032 Latency: first MemReq 1 cycle after Req is sampled; Done exactly 1 cycle after the last MemAck; minimum gap between bursts is 2 cycles.
REQ-033 MemAck in IDLE or DONE SHALL be ignored.
REQ-034 Base address bits below line alignment SHALL be forced to zero.

Reset
REQ-035 While rst_n=0 at a clock edge: state=IDLE, WordIdx=0, last-served=I, latched base/type=0.
REQ-036 All outputs SHALL be 0 during and directly after reset.
REQ-037 Reset mid-burst SHALL drop MemReq the next cycle, with no Done pulse.

Structure
REQ-038 A shared package SHALL hold the state enum, the LINE_WORDS default, and the IDX_W = clog2(LINE_WORDS) constant.
REQ-039 The word counter with wrap SHALL be one sub-module, burst_counter (enable, clear, value, last flag).

Verification
REQ-040 Lone ReqI at AddrI=0x104, MemAck every cycle: MemAddr 0x100..0x11C, 8 RValidI pulses, DoneI 1 cycle after the 8th ack, RValidD never set.
REQ-041 ReqI and ReqD raised in the same cycle after reset: D served first; I burst starts 2 cycles after DoneD; a repeat tie then grants I.
REQ-042 ReqD with WeD=1, MemAck every 3rd cycle: MemWe=1 throughout; MemWData tracks WDataD per WordIdx; no RValid pulses; DoneD after 8 acks.
REQ-043 ReqI raised during a D burst: no MemAddr change until DoneD; I granted next.
REQ-044 rst_n low after the 3rd ack of an I burst: MemReq=0, WordIdx=0 next cycle, no DoneI; a new ReqI restarts at word 0.
REQ-045 Stray MemAck in IDLE: no state change, no RValid/Done pulses.
